// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: I2C register-access master (cmd_*/wdata/rdata side, scl/sda_oe/sda_i pins, busy/done/nack_err status)
module i2c_master_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rw,
  input  logic [6:0]       cmd_dev,
  input  logic [7:0]       cmd_reg,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wdata,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  output logic             scl,
  output logic             sda_oe,
  input  logic             sda_i
);
  localparam int QW = $clog2(CLK_DIV);
  typedef enum logic [3:0] {
    IDLE, START, ADDR_W, ACK1, REG, ACK2, WREQ, WBYTE,
    WACK, RSTART, ADDR_R, ACK3, RBYTE, MACK, STOP, DONE_P
  } state_t;
  state_t state, nxt;
  logic [QW-1:0] qcnt;
  logic [1:0] q;
  logic [2:0] bcnt;
  logic rw, ack, run, qlast, samp, bit_end, byte_end, last;
  logic [6:0] dev, sh;
  logic [7:0] rg, wbuf, tx;
  logic [LEN_W-1:0] rem;
  assign run = !(state inside {IDLE, WREQ, DONE_P});
  assign qlast = qcnt == QW'(CLK_DIV - 1);
  assign samp = run && q == 2'd2 && qlast;
  assign bit_end = run && q == 2'd3 && qlast;
  assign byte_end = bit_end && bcnt == 3'd7;
  assign last = rem == LEN_W'(1);
  assign cmd_ready = state == IDLE;
  assign busy = !(state inside {IDLE, DONE_P});
  assign done = state == DONE_P;
  assign wdata_ready = state == WREQ;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      qcnt <= '0;
      q <= '0;
      bcnt <= '0;
      nack_err <= 1'b0;
      rdata <= '0;
      rdata_valid <= 1'b0;
      rw <= 1'b0;
      dev <= '0;
      rg <= '0;
      rem <= '0;
      wbuf <= '0;
      sh <= '0;
      ack <= 1'b0;
    end else begin
      state <= nxt;
      rdata_valid <= 1'b0;
      qcnt <= run && !qlast ? qcnt + 1'b1 : '0;
      q <= run ? q + 2'(qlast) : '0;
      bcnt <= (!run || nxt != state) ? '0 : bcnt + 3'(bit_end);
      if (cmd_valid && state == IDLE) begin
        rw <= cmd_rw;
        dev <= cmd_dev;
        rg <= cmd_reg;
        rem <= cmd_len;
        nack_err <= 1'b0;
      end
      if (state == WREQ && wdata_valid) wbuf <= wdata;
      if (samp) begin
        ack <= sda_i;
        sh <= {sh[5:0], sda_i};
      end
      if (samp && sda_i && state inside {ACK1, ACK2, WACK, ACK3}) nack_err <= 1'b1;
      if (samp && state == RBYTE && bcnt == 3'd7) begin
        rdata <= {sh, sda_i};
        rdata_valid <= 1'b1;
      end
      if (bit_end && state inside {WACK, MACK}) rem <= rem - 1'b1;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = cmd_valid ? START : IDLE;
      START:   nxt = bit_end ? ADDR_W : START;
      ADDR_W:  nxt = byte_end ? ACK1 : ADDR_W;
      ACK1:    nxt = !bit_end ? ACK1 : ack ? STOP : REG;
      REG:     nxt = byte_end ? ACK2 : REG;
      ACK2:    nxt = !bit_end ? ACK2 : (ack || rem == '0) ? STOP : rw ? RSTART : WREQ;
      WREQ:    nxt = wdata_valid ? WBYTE : WREQ;
      WBYTE:   nxt = byte_end ? WACK : WBYTE;
      WACK:    nxt = !bit_end ? WACK : (ack || last) ? STOP : WREQ;
      RSTART:  nxt = bit_end ? ADDR_R : RSTART;
      ADDR_R:  nxt = byte_end ? ACK3 : ADDR_R;
      ACK3:    nxt = !bit_end ? ACK3 : ack ? STOP : RBYTE;
      RBYTE:   nxt = byte_end ? MACK : RBYTE;
      MACK:    nxt = !bit_end ? MACK : last ? STOP : RBYTE;
      STOP:    nxt = bit_end ? DONE_P : STOP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    tx = state == ADDR_W ? {dev, 1'b0} : state == REG ? rg : state == WBYTE ? wbuf : {dev, 1'b1};
    scl = 1'b1;
    sda_oe = 1'b0;
    case (state)
      START: begin
        scl = q != 2'd3;
        sda_oe = q[1];
      end
      ADDR_W, REG, WBYTE, ADDR_R: begin
        scl = q[1];
        sda_oe = ~tx[~bcnt];
      end
      ACK1, ACK2, WACK, ACK3, RBYTE: scl = q[1];
      WREQ: scl = 1'b0;
      RSTART: begin
        scl = q[1];
        sda_oe = q == 2'd3 && qcnt >= QW'(CLK_DIV / 2);
      end
      MACK: begin
        scl = q[1];
        sda_oe = !last;
      end
      STOP: begin
        scl = q[1];
        sda_oe = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb_i2c_master_ctrl: transaction table plus random commands against a bus-level slave and scoreboard
module tb_i2c_master_ctrl;
  localparam int CLK_DIV = 4;
  localparam int LEN_W = 4;
  localparam logic [6:0] SLV = 7'h11;
  localparam int T_S = 1024;
  localparam int T_P = 2048;
  typedef struct {
    logic rw;
    logic [6:0] dev;
    logic [7:0] rg;
    int len;
    logic stall;
    logic seq;
    logic nack;
  } txn_t;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_rw = 1'b0, wdata_valid = 1'b0;
  logic [6:0] cmd_dev = '0;
  logic [7:0] cmd_reg = '0, wdata = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic cmd_ready, wdata_ready, rdata_valid, busy, done, nack_err, scl, sda_oe, sda_i;
  logic [7:0] rdata;
  logic spull = 1'b0;
  logic [7:0] smem [256];
  logic [7:0] ref_mem [256];
  int mon[$];
  int vecs = 0, errs = 0, tid = 0;
  assign sda_i = ~(sda_oe | spull);
  always #5 clk = ~clk;
  i2c_master_ctrl #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_len(cmd_len), .wdata(wdata),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .done(done), .nack_err(nack_err),
    .scl(scl), .sda_oe(sda_oe), .sda_i(sda_i)
  );
  // Register-file slave at address SLV; also logs bus events: START/Sr, STOP, {ack, byte}.
  initial begin
    logic line, pscl, psda, addressed, send;
    logic [7:0] rx, stx, ptr;
    int bitpos, phase;
    pscl = 1'b1; psda = 1'b1; addressed = 1'b0; send = 1'b0;
    rx = '0; stx = '0; ptr = '0; bitpos = 0; phase = 0;
    forever begin
      @(negedge clk);
      line = ~(sda_oe | spull);
      if (pscl === 1'b1 && scl === 1'b1 && psda && !line) begin
        mon.push_back(T_S); bitpos = 0; phase = 0; spull = 1'b0;
      end else if (pscl === 1'b1 && scl === 1'b1 && !psda && line) begin
        mon.push_back(T_P); bitpos = 0; phase = 0; addressed = 1'b0; spull = 1'b0;
      end else if (pscl === 1'b0 && scl === 1'b1) begin
        if (bitpos < 8) rx = {rx[6:0], line};
        else if (bitpos == 8) begin
          mon.push_back(int'({line, rx}));
          if (phase == 3) send = !line;
        end
        bitpos++;
      end else if (pscl === 1'b1 && scl === 1'b0) begin
        if (bitpos == 8) begin
          spull = 1'b0;
          case (phase)
            0: begin addressed = rx[7:1] == SLV; send = rx[0]; phase = rx[0] ? 3 : 1; spull = addressed; end
            1: begin ptr = rx; phase = 2; spull = addressed; end
            2: begin if (addressed) begin smem[ptr] = rx; ptr++; end spull = addressed; end
            default: ;
          endcase
        end else if (bitpos == 9) begin
          bitpos = 0; spull = 1'b0;
          if (phase == 3 && addressed && send) begin stx = smem[ptr]; ptr++; spull = !stx[7]; end
        end else if (bitpos > 0 && phase == 3 && addressed && send) spull = !stx[7 - bitpos];
      end
      pscl = scl;
      psda = ~(sda_oe | spull);
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL txn%0d %s: got %0d expected %0d", tid, nm, act, exp);
    end
  endtask
  task automatic run_txn(input txn_t t);
    logic [7:0] wb[$];
    int exp[$], rexp[$], got[$];
    int nwr, hs, wrc, donec, hold, bad, cyc;
    logic [7:0] d;
    nwr = 0; hs = 0; wrc = 0; donec = 0; hold = 0; bad = 0; cyc = 0;
    for (int i = 0; i < t.len; i++) wb.push_back(t.seq ? 8'(i + 1) : 8'($urandom));
    exp.push_back(T_S);
    exp.push_back(int'({t.nack, t.dev, 1'b0}));
    if (!t.nack) begin
      exp.push_back(int'(t.rg));
      if (t.len != 0 && !t.rw) begin
        nwr = t.len;
        foreach (wb[i]) begin
          exp.push_back(int'(wb[i]));
          ref_mem[8'(int'(t.rg) + i)] = wb[i];
        end
      end
      if (t.len != 0 && t.rw) begin
        exp.push_back(T_S);
        exp.push_back(int'({t.dev, 1'b1}));
        for (int i = 0; i < t.len; i++) begin
          d = ref_mem[8'(int'(t.rg) + i)];
          rexp.push_back(int'(d));
          exp.push_back((i == t.len - 1 ? 256 : 0) + int'(d));
        end
      end
    end
    exp.push_back(T_P);
    mon.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = t.rw; cmd_dev = t.dev; cmd_reg = t.rg; cmd_len = LEN_W'(t.len);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("nack_cleared", nack_err, 0);
    while (cyc < 6000 && donec == 0) begin
      if (rdata_valid) got.push_back(int'(rdata));
      if (done) donec++;
      if (wdata_ready) wrc++;
      if (t.stall && hs == 1 && hold < 100 && wdata_ready) begin
        wdata_valid = 1'b0; hold++;
        if (scl !== 1'b0) bad++;
      end else begin
        wdata_valid = wb.size() > 0;
        wdata = wb.size() > 0 ? wb[0] : 8'h00;
      end
      if (wdata_ready && wdata_valid) begin hs++; void'(wb.pop_front()); end
      @(negedge clk);
      cyc++;
    end
    wdata_valid = 1'b0;
    repeat (3) begin @(negedge clk); if (done) donec++; end
    chk("done_pulses", donec, 1);
    chk("nack_err", nack_err, int'(t.nack));
    chk("busy_end", busy, 0);
    chk("cmd_ready_end", cmd_ready, 1);
    chk("wdata_handshakes", hs, nwr);
    if (nwr == 0) chk("wdata_ready_cycles", wrc, 0);
    if (t.stall) begin
      chk("stall_cycles", hold, 100);
      chk("stall_scl_high_cycles", bad, 0);
    end
    chk("rdata_count", got.size(), rexp.size());
    foreach (rexp[i]) chk("rdata", i < got.size() ? got[i] : -1, rexp[i]);
    chk("bus_token_count", mon.size(), exp.size());
    foreach (exp[i]) chk("bus_token", i < mon.size() ? mon[i] : -1, exp[i]);
  endtask
  initial begin
    txn_t tbl[9];
    txn_t r;
    for (int i = 0; i < 256; i++) begin
      smem[i] = 8'(i * 37 + 11);
      ref_mem[i] = 8'(i * 37 + 11);
    end
    tbl[0] = '{1'b0, 7'h11, 8'h00, 8, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 7'h11, 8'h05, 3, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 7'h12, 8'h00, 2, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 7'h11, 8'h20, 2, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 7'h11, 8'h30, 0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 7'h12, 8'h00, 2, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 7'h11, 8'h1F, 3, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 7'h11, 8'h07, 0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 7'h11, 8'hF8, 15, 1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_wdata_ready", wdata_ready, 0);
    chk("rst_nack_err", nack_err, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tid = k;
      run_txn(tbl[k]);
    end
    tid = 100;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev = SLV; cmd_reg = 8'h40; cmd_len = LEN_W'(1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (200) @(negedge clk);
    chk("mid_reg_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_scl", scl, 1);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    tid = 101;
    run_txn('{1'b1, 7'h11, 8'h40, 2, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < 8; k++) begin
      tid = 200 + k;
      r.rw = 1'($urandom);
      r.dev = ($urandom_range(3) == 0) ? 7'h13 : SLV;
      r.rg = 8'($urandom);
      r.len = $urandom_range(15);
      r.stall = 1'b0;
      r.seq = 1'b0;
      r.nack = r.dev != SLV;
      run_txn(r);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- I2C master sequencer that drives the I2C_Slave register interface: START, 7-bit device address, 8-bit register pointer, N write bytes or repeated-START plus N read bytes, then STOP.
- Sits between a local command/data interface and the board-level SCL/SDA pins.
- SDA is open-drain: the block only pulls low or releases. SCL is push-pull from the block; there is no clock-stretch input.
- Reports slave NACK and returns read bytes one at a time.

Parameters:
- CLK_DIV, 4, clk cycles per quarter SCL bit; one bit = 4*CLK_DIV clk; must be >= 2.
- LEN_W, 4, width of the byte-count field.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_rw  in  1  0=write, 1=read
- cmd_dev  in  7  slave device address
- cmd_reg  in  8  register pointer
- cmd_len  in  LEN_W  data byte count, 0 allowed
- wdata  in  8  write byte
- wdata_valid  in  1  write byte available
- wdata_ready  out  1  master requesting the next write byte
- rdata  out  8  received byte
- rdata_valid  out  1  one-cycle pulse per received byte
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse after STOP completes
- nack_err  out  1  sticky slave NACK; cleared on next accepted command
- scl  out  1  I2C clock
- sda_oe  out  1  1 = pull SDA low
- sda_i  in  1  SDA pin level

Behaviour:
- Reset (sync, any state) forces IDLE with:
  - scl=1, sda_oe=0, cmd_ready=1
  - busy=0, done=0, rdata_valid=0, wdata_ready=0, nack_err=0, rdata=0
  - quarter counter and bit counter cleared
- Reset mid-transaction releases the bus immediately. No STOP is generated.
- Command accept: cmd_valid && cmd_ready latches all cmd_* fields, clears nack_err, and sets busy on the next cycle.
- Bit timing:
  - quarter tick every CLK_DIV clk
  - q0, q1: scl=0; q2, q3: scl=1
  - sda_oe updates only at the start of q0
  - sda_i is sampled on the last clk of q2
- States and transitions:
  - IDLE
  - START: SDA released / SCL high for q0-q1; pull SDA at q2; SCL low at q3.
  - ADDR_W: 8 bits = cmd_dev, 0, MSB first.
  - ACK1: release SDA, sample. 1 = NACK, go to STOP.
  - REG: 8 bits of cmd_reg.
  - ACK2: NACK goes to STOP. Otherwise: if len==0 go to STOP; if rw=0 go to WREQ; if rw=1 go to RSTART.
  - WREQ: scl held low, wdata_ready=1 until wdata_valid. The handshake cycle latches wdata, then go to WBYTE. Stalling indefinitely is legal.
  - WBYTE: 8 bits.
  - WACK: NACK goes to STOP. Then decrement remaining; if 0 go to STOP, else go to WREQ.
  - RSTART: SDA released with SCL low in q0-q1; SCL high q2; SDA pulled mid-q3; then SCL low.
  - ADDR_R: cmd_dev, 1.
  - ACK3: NACK goes to STOP.
  - RBYTE: release SDA, shift 8 samples MSB first.
  - MACK: drive ACK (sda_oe=1) if bytes remain, NACK (release) on the last byte.
  - Read byte output: rdata updated and rdata_valid pulsed in the cycle after the 8th sample.
  - MACK, then RBYTE or STOP.
  - STOP: sda_oe=1 in q0; scl high q2; SDA released at q3 end.
  - DONE_P: done=1 for one cycle, busy drops, return to IDLE.
- NACK path: nack_err set in the sample cycle and held until the next command. done is still pulsed.
- Byte count: cmd_len up to 2^LEN_W-1 bytes. A latched count of 0 performs a pointer-only transaction.

Test Plan:
- Write burst: dev=0x11, reg=0x00, len=8, wdata 0x01..0x08 presented immediately -> SDA serialises 0x22, 0x00, 0x01..0x08, STOP; slave regs 0..7 = 1..8; done pulses once; nack_err=0.
- Repeated-START read: after the above, read dev=0x11, reg=0x05, len=3 -> bus shows 0x22, 0x05, Sr, 0x23; rdata_valid pulses with 0x06, 0x07, 0x08; master ACK, ACK, NACK; STOP; done.
- Address NACK: dev=0x12 with no responding slave -> ACK1 samples 1; STOP follows immediately; nack_err=1; no wdata_ready; done pulses; next command clears nack_err.
- Write underrun: len=2, wdata_valid withheld 100 clk before the second byte -> scl stays 0 throughout; wdata_ready high; byte sent correctly after valid.
- Pointer-only: rw=0, len=0 -> START, 0x22, reg, STOP; wdata_ready never asserted.
- Reset mid-REG byte -> the next clk shows scl=1, sda_oe=0, busy=0, cmd_ready=1; a fresh command then completes normally.
